// File: rtl/gpgpu_fifo_pkg.sv
// Width helpers shared by the GPGPU FIFO family.
package gpgpu_fifo_pkg;

    function automatic int unsigned cnt_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned addr_width(int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Ready/valid handshake bundle for stream_fifo; slave is the FIFO's view, master the peer's.
interface stream_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/stream_fifo_ptr.sv
// FIFO pointer that counts 0..DEPTH-1 and wraps explicitly, so any depth works.
module stream_fifo_ptr
    import gpgpu_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/stream_fifo.sv
// Ready/valid synchronous FIFO with occupancy, almost flags and flush.
// Optional high-water mark output peak_o when STREAM_FIFO_PEAK_EN is defined.
module stream_fifo
    import gpgpu_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned AF_LEVEL   = (FIFO_DEPTH > 1) ? FIFO_DEPTH - 1 : 1,
    parameter  int unsigned AE_LEVEL   = (FIFO_DEPTH > 1) ? 1 : 0,
    localparam int unsigned CNT_W      = cnt_width(FIFO_DEPTH),
    localparam int unsigned ADDR_W     = addr_width(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    stream_fifo_if.slave     bus,
    output logic [CNT_W-1:0] count_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
`ifdef STREAM_FIFO_PEAK_EN
    ,
    output logic [CNT_W-1:0] peak_o
`endif
);
    if (FIFO_DEPTH == 0) begin : g_chk_depth
        $error("stream_fifo: FIFO_DEPTH must be >= 1");
    end
    if (AF_LEVEL == 0 || AF_LEVEL > FIFO_DEPTH) begin : g_chk_af
        $error("stream_fifo: AF_LEVEL must be in 1..FIFO_DEPTH");
    end
    if (AE_LEVEL >= FIFO_DEPTH) begin : g_chk_ae
        $error("stream_fifo: AE_LEVEL must be in 0..FIFO_DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, pop;

    // Ready/valid come only from registered count and flush: no through paths.
    assign bus.in_ready_o  = (cnt_q != CNT_W'(FIFO_DEPTH)) && !flush_i;
    assign bus.out_valid_o = (cnt_q != '0) && !flush_i;
    assign push            = bus.in_valid_i && bus.in_ready_o;
    assign pop             = bus.out_valid_o && bus.out_ready_i;
    assign bus.out_data_o  = mem_q[rd_ptr];

    stream_fifo_ptr #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    stream_fifo_ptr #(
        .DEPTH (FIFO_DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush_i),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= bus.in_data_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o        = cnt_q;
    assign almost_full_o  = 32'(cnt_q) >= AF_LEVEL;
    assign almost_empty_o = 32'(cnt_q) <= AE_LEVEL;

`ifdef STREAM_FIFO_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush_i) begin
            peak_d = '0;
        end else if (cnt_d > peak_q) begin
            peak_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (depth 5, 8-bit) with a queue scoreboard and reference count.
module tb_stream_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned AF    = 4;
    localparam int unsigned AE    = 1;

    logic       clk;
    logic       rst_n;
    logic       flush_i;
    logic [2:0] count_o;
    logic       almost_full_o;
    logic       almost_empty_o;
`ifdef STREAM_FIFO_PEAK_EN
    logic [2:0] peak_o;
`endif

    stream_fifo_if #(.DATA_WIDTH(DW)) bus ();

    stream_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .bus            (bus),
        .count_o        (count_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
`ifdef STREAM_FIFO_PEAK_EN
        ,
        .peak_o         (peak_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];
    int            m_cnt  = 0;
    int            m_peak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge; check combinational view, then commit the model at posedge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        logic exp_rdy, exp_vld, do_push, do_pop;
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        flush_i         = f;
        exp_rdy = (m_cnt != DEPTH) && !f;
        exp_vld = (m_cnt != 0) && !f;
        #1;
        chk("in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid_o), 32'(exp_vld));
        chk("count", 32'(count_o), m_cnt);
        chk("almost_full", 32'(almost_full_o), 32'(m_cnt >= AF));
        chk("almost_empty", 32'(almost_empty_o), 32'(m_cnt <= AE));
`ifdef STREAM_FIFO_PEAK_EN
        chk("peak", 32'(peak_o), m_peak);
`endif
        if (exp_vld) chk("out_data", 32'(bus.out_data_o), 32'(sb[0]));
        do_push = v && exp_rdy;
        do_pop  = r && exp_vld;
        @(posedge clk);
        if (f) begin
            sb.delete();
            m_cnt  = 0;
            m_peak = 0;
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(d);
            m_cnt = sb.size();
            if (m_cnt > m_peak) m_peak = m_cnt;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        flush_i         = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_af", 32'(almost_full_o), 32'd0);
        chk("rst_ae", 32'(almost_empty_o), 32'd1);
`ifdef STREAM_FIFO_PEAK_EN
        chk("rst_peak", 32'(peak_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill with back-pressure, then drain in order.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hee, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Hold count at 2 across several pointer wraps.
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'h22 + 8'(i), 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Full: same-cycle pop does not open the input.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        cyc(1'b1, 8'h56, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty: no bypass, data visible one cycle later.
        cyc(1'b1, 8'ha5, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at count 3 with both sides active.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // High-water mark: fill 4, drain, refill 2.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-fill, between clock edges.
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hc3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(count_o), 32'd0);
        chk("async_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready_o), 32'd1);
`ifdef STREAM_FIFO_PEAK_EN
        chk("async_peak", 32'(peak_o), 32'd0);
`endif
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_cnt  = 0;
        m_peak = 0;
        cyc(1'b1, 8'h3c, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
